// File: rtl/bitty_core_param.sv
// Parametrised multi-cycle accumulator core: one instruction per run handshake,
// sequenced through latch / load / execute / write-back with a debug read port.
module bitty_core_param #(
   parameter int DATA_W  = 16,
   parameter int REG_CNT = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [15:0]                instruction,
   input  logic                       run,
   output logic                       done,
   output logic                       busy,
   output logic [1:0]                 flags,
   input  logic [$clog2(REG_CNT)-1:0] dbg_sel,
   output logic [DATA_W-1:0]          dbg_data
);

   localparam int RI_W = $clog2(REG_CNT);
   localparam logic [DATA_W-1:0] DW_VAL = DATA_W'(DATA_W);

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} stateT;

   stateT             state_q;
   logic [DATA_W-1:0] regFile_q [REG_CNT];
   logic [DATA_W-1:0] sReg_q;
   logic [DATA_W-1:0] cReg_q;
   logic [15:0]       instr_q;
   logic [1:0]        flags_q;
   logic              done_q;
   logic              busy_q;

   logic [RI_W-1:0]   rxIdx;
   logic [RI_W-1:0]   ryIdx;
   logic [2:0]        opCode;
   logic [1:0]        fmt;
   logic [DATA_W-1:0] opB;
   logic [DATA_W:0]   sumW;
   logic [DATA_W-1:0] aluRes_d;
   logic              aluCarry_d;

   assign rxIdx  = instr_q[13 +: RI_W];
   assign ryIdx  = instr_q[10 +: RI_W];
   assign opCode = instr_q[4:2];
   assign fmt    = instr_q[1:0];
   assign sumW   = {1'b0, sReg_q} + {1'b0, opB};

   // Reserved formats also take the immediate path; their result is discarded.
   always_comb begin
      opB = '0;
      if (fmt == 2'b00) begin
         opB = regFile_q[ryIdx];
      end else begin
         opB[7:0] = instr_q[12:5];
      end
   end

   always_comb begin
      aluRes_d   = '0;
      aluCarry_d = 1'b0;
      case (opCode)
         3'b000: begin
            aluRes_d   = sumW[DATA_W-1:0];
            aluCarry_d = sumW[DATA_W];
         end
         3'b001: begin
            aluRes_d   = sReg_q - opB;
            aluCarry_d = (sReg_q < opB);
         end
         3'b010: aluRes_d = sReg_q & opB;
         3'b011: aluRes_d = sReg_q | opB;
         3'b100: aluRes_d = sReg_q ^ opB;
         3'b101: if (opB < DW_VAL) aluRes_d = sReg_q << opB;
         3'b110: if (opB < DW_VAL) aluRes_d = sReg_q >> opB;
         default: begin
            if (sReg_q > opB) begin
               aluRes_d[0] = 1'b1;
            end else if (sReg_q < opB) begin
               aluRes_d[1] = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         for (int i = 0; i < REG_CNT; i++) begin
            regFile_q[i] <= '0;
         end
         sReg_q  <= '0;
         cReg_q  <= '0;
         instr_q <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (run) begin
                  instr_q <= instruction;
                  busy_q  <= 1'b1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               sReg_q  <= regFile_q[rxIdx];
               state_q <= EXEC;
            end
            EXEC: begin
               cReg_q <= aluRes_d;
               if (!fmt[1]) begin
                  flags_q <= {aluCarry_d, (aluRes_d == '0)};
               end
               state_q <= WB;
            end
            default: begin
               if (!fmt[1]) begin
                  regFile_q[rxIdx] <= cReg_q;
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign done     = done_q;
   assign busy     = busy_q;
   assign flags    = flags_q;
   assign dbg_data = regFile_q[dbg_sel];

endmodule

// File: tb/tb_bitty_core_param.sv
// Directed bench for bitty_core_param: a reference model pushes expected
// write-back results to a queue at acceptance; they are popped on done.
module tb_bitty_core_param;

   logic        clk;
   logic        reset;
   logic [15:0] instruction;
   logic        run;
   logic        done;
   logic        busy;
   logic [1:0]  flags;
   logic [2:0]  dbg_sel;
   logic [15:0] dbg_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  rx;
      logic [15:0] value;
      logic [1:0]  flg;
   } expT;

   expT         sbQ[$];
   logic [15:0] mRegs [8];
   logic [1:0]  mFlags;

   bitty_core_param #(.DATA_W(16), .REG_CNT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .run         (run),
      .done        (done),
      .busy        (busy),
      .flags       (flags),
      .dbg_sel     (dbg_sel),
      .dbg_data    (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] encImm(input logic [2:0] rx, input logic [7:0] imm, input logic [2:0] op);
      return {rx, imm, op, 2'b01};
   endfunction

   function automatic logic [15:0] encReg(input logic [2:0] rx, input logic [2:0] ry,
                                          input logic [2:0] op, input logic [1:0] fm);
      return {rx, ry, 5'b00000, op, fm};
   endfunction

   // Reference model: applies the instruction to the shadow registers and queues the outcome.
   task automatic pushModel(input logic [15:0] instr);
      logic [2:0]  rx;
      logic [15:0] a, b, res;
      logic [16:0] wide;
      logic        cy;
      expT         e;
      rx = instr[15:13];
      if (instr[1]) begin
         e.rx = rx; e.value = mRegs[rx]; e.flg = mFlags;
      end else begin
         a  = mRegs[rx];
         b  = (instr[1:0] == 2'b00) ? mRegs[instr[12:10]] : {8'h00, instr[12:5]};
         cy = 1'b0;
         case (instr[4:2])
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; res = wide[15:0]; cy = wide[16]; end
            3'd1: begin res = a - b; cy = (a < b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (b > 16'd15) ? 16'h0000 : (a << b[3:0]);
            3'd6: res = (b > 16'd15) ? 16'h0000 : (a >> b[3:0]);
            default: res = (a == b) ? 16'd0 : ((a > b) ? 16'd1 : 16'd2);
         endcase
         mRegs[rx] = res;
         mFlags    = {cy, (res == 16'h0000)};
         e.rx = rx; e.value = res; e.flg = mFlags;
      end
      sbQ.push_back(e);
   endtask

   // Issue one instruction from just after a falling edge and retire it on done.
   task automatic applyStimulus(input logic [15:0] instr, input bit holdRun,
                                input bit pulseBusy, input logic [15:0] intruder);
      int  cyc = 0;
      bit  seen = 1'b0;
      expT e;
      instruction = instr;
      run         = 1'b1;
      checkOutput("idle_before_accept", {31'd0, busy}, 32'd0);
      @(posedge clk);
      pushModel(instr);
      while (!seen && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            checkOutput("busy_in_load", {31'd0, busy}, 32'd1);
            checkOutput("no_done_in_load", {31'd0, done}, 32'd0);
            instruction = intruder;
            if (!holdRun) run = 1'b0;
         end
         if (cyc == 2 && pulseBusy) run = 1'b1;
         if (cyc == 3 && pulseBusy && !holdRun) run = 1'b0;
         if (done) seen = 1'b1;
      end
      checkOutput("done_latency", cyc, 32'd4);
      if (sbQ.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sbQ.pop_front();
         dbg_sel = e.rx;
         #1;
         checkOutput($sformatf("reg_r%0d_after_%h", e.rx, instr), {16'd0, dbg_data}, {16'd0, e.value});
         checkOutput($sformatf("flags_after_%h", instr), {30'd0, flags}, {30'd0, e.flg});
      end
   endtask

   initial begin
      int doneSeen;
      reset       = 1'b0;
      run         = 1'b0;
      instruction = 16'h0000;
      dbg_sel     = 3'd0;
      mFlags      = 2'b00;
      for (int i = 0; i < 8; i++) mRegs[i] = 16'h0000;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] reset state");
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_flags", {30'd0, flags}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         dbg_sel = 3'(i);
         #1;
         checkOutput($sformatf("reset_r%0d", i), {16'd0, dbg_data}, 32'd0);
      end

      $display("[TB] immediates, add, sub, compare");
      applyStimulus(16'h20A1, 1'b0, 1'b0, 16'hFFFF);
      applyStimulus(16'h5FE1, 1'b0, 1'b0, 16'hFFFF);
      applyStimulus(16'h2800, 1'b0, 1'b0, 16'hFFFF);
      applyStimulus(16'h4404, 1'b0, 1'b0, 16'hFFFF);
      applyStimulus(16'h241C, 1'b0, 1'b0, 16'hFFFF);

      $display("[TB] back-to-back with run held");
      applyStimulus(encImm(3'd3, 8'h0F, 3'd3), 1'b1, 1'b0, encImm(3'd3, 8'hFF, 3'd0));
      applyStimulus(encImm(3'd3, 8'd4, 3'd5), 1'b1, 1'b0, encImm(3'd3, 8'hFF, 3'd0));
      applyStimulus(encImm(3'd4, 8'h3C, 3'd4), 1'b1, 1'b0, encImm(3'd4, 8'hFF, 3'd0));
      applyStimulus(encReg(3'd3, 3'd4, 3'd2, 2'b00), 1'b0, 1'b0, encImm(3'd3, 8'hFF, 3'd0));

      $display("[TB] run pulsed while busy");
      applyStimulus(encImm(3'd5, 8'h12, 3'd0), 1'b0, 1'b1, encImm(3'd5, 8'hAA, 3'd4));

      $display("[TB] shifts, compares, carry boundaries");
      applyStimulus(encImm(3'd2, 8'd4, 3'd6), 1'b0, 1'b0, 16'h0000);
      applyStimulus(encImm(3'd2, 8'd16, 3'd5), 1'b0, 1'b0, 16'h0000);
      applyStimulus(encImm(3'd6, 8'd1, 3'd7), 1'b0, 1'b0, 16'h0000);
      applyStimulus(encImm(3'd3, 8'd1, 3'd7), 1'b0, 1'b0, 16'h0000);
      applyStimulus(encImm(3'd7, 8'd1, 3'd1), 1'b0, 1'b0, 16'h0000);
      applyStimulus(encImm(3'd7, 8'd1, 3'd0), 1'b0, 1'b0, 16'h0000);

      $display("[TB] reserved format");
      applyStimulus(encReg(3'd1, 3'd3, 3'd0, 2'b10), 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      checkOutput("done_single_cycle", {31'd0, done}, 32'd0);

      $display("[TB] async reset during execute");
      instruction = encImm(3'd4, 8'h55, 3'd0);
      run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_flags", {30'd0, flags}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         dbg_sel = 3'(i);
         #1;
         checkOutput($sformatf("abort_r%0d", i), {16'd0, dbg_data}, 32'd0);
      end
      doneSeen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("abort_no_done", doneSeen, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
